// File: rtl/exe_mem_skid_reg_pkg.sv
// Shared EXE->MEM pipeline definitions: payload layout, occupancy encoding and default widths.
package exe_mem_skid_reg_pkg;

  localparam int EM_DATA_W = 32;
  localparam int EM_DEST_W = 4;

  typedef struct packed {
    logic                 wb_en;
    logic                 mem_r_en;
    logic                 mem_w_en;
    logic [EM_DATA_W-1:0] alu_res;
    logic [EM_DATA_W-1:0] val_rm;
    logic [EM_DEST_W-1:0] dest;
  } em_payload_t;

  // The state value is the occupancy count, so it is exported unchanged.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/exe_mem_skid_reg_if.sv
// EXE->MEM handshake bundle. Handshake: a beat moves on an edge where valid and ready are
// both high; the producer keeps valid and data stable until that happens.
interface exe_mem_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              WB_EN_IN;
  logic              MEM_R_EN_IN;
  logic              MEM_W_EN_IN;
  logic [DATA_W-1:0] ALU_RES_IN;
  logic [DATA_W-1:0] Val_Rm_IN;
  logic [DEST_W-1:0] Dest_IN;
  logic              in_ready;
  logic              mem_ready;
  logic              out_valid;
  logic              WB_EN;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [DATA_W-1:0] ALU_RES;
  logic [DATA_W-1:0] Val_Rm;
  logic [DEST_W-1:0] Dest;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output in_valid, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, ALU_RES_IN, Val_Rm_IN, Dest_IN,
    output mem_ready,
    input  in_ready, out_valid, WB_EN, MEM_R_EN, MEM_W_EN, ALU_RES, Val_Rm, Dest,
    input  occupancy, stall_cnt
  );

  modport slave (
    input  in_valid, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, ALU_RES_IN, Val_Rm_IN, Dest_IN,
    input  mem_ready,
    output in_ready, out_valid, WB_EN, MEM_R_EN, MEM_W_EN, ALU_RES, Val_Rm, Dest,
    output occupancy, stall_cnt
  );
endinterface

// File: rtl/exe_mem_skid_reg_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register built as a 2-entry skid buffer; back-pressure to EXE is registered
// and all outputs come straight from the head register.
module exe_mem_skid_reg
  import exe_mem_skid_reg_pkg::*;
#(
  parameter int DATA_W = EM_DATA_W,
  parameter int DEST_W = EM_DEST_W,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  exe_mem_skid_reg_if.slave bus
);

  occ_e        state_q, state_d;
  em_payload_t head_q, head_d;
  em_payload_t skid_q, skid_d;
  em_payload_t in_pl;
  logic        in_ready_q;
  logic        out_valid;
  logic        accept;
  logic        take;

  always_comb begin
    in_pl          = '0;
    in_pl.wb_en    = bus.WB_EN_IN;
    in_pl.mem_r_en = bus.MEM_R_EN_IN;
    in_pl.mem_w_en = bus.MEM_W_EN_IN;
    in_pl.alu_res  = EM_DATA_W'(bus.ALU_RES_IN);
    in_pl.val_rm   = EM_DATA_W'(bus.Val_Rm_IN);
    in_pl.dest     = EM_DEST_W'(bus.Dest_IN);
  end

  assign out_valid = (state_q != OCC_EMPTY);
  assign accept    = bus.in_valid & in_ready_q;
  assign take      = out_valid & bus.mem_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          head_d  = in_pl;
          state_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && take) begin
          head_d = in_pl;
        end else if (accept) begin
          skid_d  = in_pl;
          state_d = OCC_FULL;
        end else if (take) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (take) begin
          head_d  = skid_q;
          state_d = OCC_ONE;
        end
      end
      default: begin
        state_d = OCC_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= OCC_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != OCC_FULL);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.WB_EN     = head_q.wb_en & out_valid;
  assign bus.MEM_R_EN  = head_q.mem_r_en & out_valid;
  assign bus.MEM_W_EN  = head_q.mem_w_en & out_valid;
  assign bus.ALU_RES   = DATA_W'(head_q.alu_res);
  assign bus.Val_Rm    = DATA_W'(head_q.val_rm);
  assign bus.Dest      = DEST_W'(head_q.dest);
  assign bus.occupancy = state_q;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst),
    .en    (out_valid & ~bus.mem_ready),
    .count (bus.stall_cnt)
  );

endmodule
